// File: rtl/soh_pkg.sv
// Shared definitions for the shifter operand handler front end.
//   - Field widths for the S mode and I immediate, data and counter widths.
//   - Requester id enum: SOH_PORT_EXE (execute operand path), SOH_PORT_AGU (address generation).
//   - Shifter mode encoding consumed by operand_handler.
package soh_pkg;

  localparam int unsigned SohDataW = 32;
  localparam int unsigned SohModeW = 3;
  localparam int unsigned SohImmW  = 21;
  localparam int unsigned SohCntW  = 16;

  typedef enum logic {
    SOH_PORT_EXE = 1'b0,
    SOH_PORT_AGU = 1'b1
  } soh_port_e;

  // Shift amount for the shift/rotate modes comes from I[4:0].
  typedef enum logic [SohModeW-1:0] {
    ModeReg     = 3'd0,  // N = RB
    ModeImmSext = 3'd1,  // N = sign-extended I
    ModeLsl     = 3'd2,  // N = RB << I[4:0]
    ModeLsr     = 3'd3,  // N = RB >> I[4:0] (logical)
    ModeAsr     = 3'd4,  // N = RB >>> I[4:0] (arithmetic)
    ModeRor     = 3'd5,  // N = RB rotated right by I[4:0]
    ModeImmHi   = 3'd6,  // N = {I, 11'b0}
    ModeImmZext = 3'd7   // N = zero-extended I
  } soh_mode_e;

endpackage

// File: rtl/operand_handler.sv
// Combinational shifter operand handler.
// Ports:
//   rb   [31:0] register operand RB
//   imm  [20:0] immediate field I
//   mode [2:0]  shifter mode S (see soh_mode_e)
//   n    [31:0] resulting operand N
module operand_handler
  import soh_pkg::*;
(
  input  logic [SohDataW-1:0] rb,
  input  logic [SohImmW-1:0]  imm,
  input  logic [SohModeW-1:0] mode,
  output logic [SohDataW-1:0] n
);

  logic [4:0] sh;

  assign sh = imm[4:0];

  always_comb begin
    n = rb;
    unique case (soh_mode_e'(mode))
      ModeReg:     n = rb;
      ModeImmSext: n = {{(SohDataW - SohImmW){imm[SohImmW-1]}}, imm};
      ModeLsl:     n = rb << sh;
      ModeLsr:     n = rb >> sh;
      ModeAsr:     n = SohDataW'($signed(rb) >>> sh);
      // A left shift by 32 (sh == 0) yields zero, so the OR reduces to rb.
      ModeRor:     n = (rb >> sh) | (rb << (6'd32 - {1'b0, sh}));
      ModeImmHi:   n = {imm, {(SohDataW - SohImmW){1'b0}}};
      ModeImmZext: n = {{(SohDataW - SohImmW){1'b0}}, imm};
      default:     n = rb;
    endcase
  end

endmodule

// File: rtl/soh_rr_arbiter.sv
// Two-way round-robin arbiter with its priority register.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   valid [1:0]  request valids, bit i = port i
//   accept       the granted job was taken this cycle
//   grant [1:0]  one-hot grant
//   grant_id     granted port as an id
// A lone valid port is granted; otherwise (both or none) the port named by prio wins.
module soh_rr_arbiter
  import soh_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output soh_port_e  grant_id
);

  logic prio_q;

  always_comb begin
    grant_id = soh_port_e'(prio_q);
    unique case (valid)
      2'b01:   grant_id = SOH_PORT_EXE;
      2'b10:   grant_id = SOH_PORT_AGU;
      default: grant_id = soh_port_e'(prio_q);
    endcase
    grant = (grant_id == SOH_PORT_AGU) ? 2'b10 : 2'b01;
  end

  // Priority moves to the port that lost; held when nothing is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (accept) begin
      prio_q <= (grant_id == SOH_PORT_EXE);
    end
  end

endmodule

// File: rtl/soh_op_arbiter.sv
// Shares one operand_handler between the execute operand path (port 0) and the
// address-generation path (port 1) with round-robin arbitration, and registers the
// result behind a valid/ready handshake with pipeline flush.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqX_valid/ready                request handshake, X = 0 (EXE), 1 (AGU)
//   reqX_rb/imm/mode/tag            RB, I, S and destination tag of the request
//   flush                           drop the held result, accept nothing this cycle
//   out_valid/ready                 result handshake
//   out_n, out_id, out_tag          result N, producing port, request tag
// Optional (SOH_ARB_STATS_EN defined):
//   grant0_cnt, grant1_cnt          saturating per-port accept counters
module soh_op_arbiter
  import soh_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [SohDataW-1:0] req0_rb,
  input  logic [SohImmW-1:0]  req0_imm,
  input  logic [SohModeW-1:0] req0_mode,
  input  logic [TAG_W-1:0]    req0_tag,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [SohDataW-1:0] req1_rb,
  input  logic [SohImmW-1:0]  req1_imm,
  input  logic [SohModeW-1:0] req1_mode,
  input  logic [TAG_W-1:0]    req1_tag,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SohDataW-1:0] out_n,
  output logic                out_id,
  output logic [TAG_W-1:0]    out_tag
`ifdef SOH_ARB_STATS_EN
  ,
  output logic [SohCntW-1:0]  grant0_cnt,
  output logic [SohCntW-1:0]  grant1_cnt
`endif
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e              state_q;
  logic                can_accept;
  logic                accept;
  logic [1:0]          grant;
  soh_port_e           grant_id;
  logic [SohDataW-1:0] sel_rb;
  logic [SohImmW-1:0]  sel_imm;
  logic [SohModeW-1:0] sel_mode;
  logic [TAG_W-1:0]    sel_tag;
  logic [SohDataW-1:0] handler_n;

  assign out_valid = (state_q == StFull);

  // rst_n gates readiness so nothing is offered while reset is asserted.
  assign can_accept = rst_n && !flush && (!out_valid || out_ready);
  assign req0_ready = can_accept && grant[0];
  assign req1_ready = can_accept && grant[1];
  assign accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);

  soh_rr_arbiter u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    ({req1_valid, req0_valid}),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_comb begin
    sel_rb   = req0_rb;
    sel_imm  = req0_imm;
    sel_mode = req0_mode;
    sel_tag  = req0_tag;
    if (grant_id == SOH_PORT_AGU) begin
      sel_rb   = req1_rb;
      sel_imm  = req1_imm;
      sel_mode = req1_mode;
      sel_tag  = req1_tag;
    end
  end

  operand_handler u_handler (
    .rb   (sel_rb),
    .imm  (sel_imm),
    .mode (sel_mode),
    .n    (handler_n)
  );

  // Result FSM; flush takes precedence over both accept and out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      out_n   <= '0;
      out_id  <= 1'b0;
      out_tag <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (!flush && accept) begin
            state_q <= StFull;
          end
        end
        StFull: begin
          if (flush || (out_ready && !accept)) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
      if (accept) begin
        out_n   <= handler_n;
        out_id  <= grant_id;
        out_tag <= sel_tag;
      end
    end
  end

`ifdef SOH_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
    end else if (accept) begin
      if (grant_id == SOH_PORT_EXE) begin
        if (grant0_cnt != '1) grant0_cnt <= grant0_cnt + SohCntW'(1);
      end else begin
        if (grant1_cnt != '1) grant1_cnt <= grant1_cnt + SohCntW'(1);
      end
    end
  end
`endif

endmodule

// File: doc/soh_op_arbiter.md
# soh_op_arbiter

Sequential front end for the shifter operand handler (`operand_handler`: RB, 21-bit I, 3-bit mode S -> 32-bit N). It shares the single handler between two requesters, the execute-stage operand path (port 0) and the address-generation path (port 1), using round-robin arbitration. It registers the result with a valid/ready handshake and supports a pipeline flush. The block sits between decode/issue and the ALU/AGU operand muxes.

## Interface
- `TAG_W`, default 5: width of the per-request tag (destination register id) carried alongside each request.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req0_valid` / `req1_valid` input 1: requester has an operand job.
- `req0_ready` / `req1_ready` output 1: job accepted this cycle.
- `req0_rb` / `req1_rb` input 32: RB operand.
- `req0_imm` / `req1_imm` input 21: I immediate field.
- `req0_mode` / `req1_mode` input 3: S shifter mode.
- `req0_tag` / `req1_tag` input TAG_W: tag returned with the result.
- `flush` input 1: discard the held result and accept nothing this cycle.
- `out_valid` output 1: result register holds a result.
- `out_ready` input 1: consumer takes the result.
- `out_n` output 32: registered handler output N.
- `out_id` output 1: requester that produced `out_n`.
- `out_tag` output TAG_W: tag of that request.

## Operation
- FSM has two states, from `out_valid`:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept while `out_ready`=1 (back-to-back).
  - FULL -> EMPTY on `out_ready`=1 with no accept.
  - Any state -> EMPTY on `flush`.
- `can_accept = !flush && (!out_valid || out_ready)`.
- Arbitration:
  - Round-robin pointer `prio`: 0 favours port 0, 1 favours port 1.
  - If only one port is valid, it is granted.
  - If both are valid, the port equal to `prio` is granted.
  - `reqX_ready = can_accept && grant==X`. At most one ready is high per cycle.
  - After every accepted job, `prio` is set to the non-granted port. With no accept, `prio` holds.
- The granted port's RB/I/S drive one combinational `operand_handler` instance. On accept, `out_n`, `out_id` and `out_tag` load together.
- `ready` never depends on the requester's own `valid` for the other port, so there are no combinational loops through requesters. `req*_ready` depends combinationally on `out_ready` and `flush`.
- Out-of-range mode values are passed unchanged to the handler. The arbiter does not interpret S.

## Timing
- Latency is 1 cycle: a job accepted at edge k is visible on `out_*` after edge k. Throughput is 1 job per cycle while `out_ready`=1.
- `out_*` is stable while `out_valid && !out_ready && !flush`.
- Reset (asynchronous, takes effect immediately):
  - `out_valid`=0, `out_n`=0, `out_id`=0, `out_tag`=0, `prio`=0.
  - Both `req*_ready`=0 while `rst_n`=0.
- Reset mid-transaction drops the held result. No job is accepted during reset.
- `flush` and `out_ready` in the same cycle: the flush wins. `out_valid` goes to 0 and the consumer must ignore that transfer.
- `flush` with both requests valid: neither request is accepted and `prio` is unchanged.

## Configuration
- `SOH_ARB_STATS_EN` defined adds:
  - Outputs `grant0_cnt` and `grant1_cnt`, 16-bit each, counting accepted jobs per port.
  - The counters saturate at 16'hFFFF, reset to 0 and are unaffected by `flush`.
- Undefined: no counters and no extra ports. Behaviour is otherwise identical.

## Structure
- Shared package `soh_pkg` holds:
  - The S mode width constant (3) and immediate width constant (21).
  - The requester id enum (`SOH_PORT_EXE`=0, `SOH_PORT_AGU`=1).
  - The counter width (16).
- Sub-module `soh_rr_arbiter` holds the 2-way round-robin grant and `prio` register (inputs: valids, accept; outputs: grant, grant_id).
- `operand_handler` is instanced unchanged.

## Test plan
- **Single request, reset released:** port 0 valid with RB=32'h8431FFEB, I=21'h104761, S=3'b000, tag=5'd3.
  - Required: `req0_ready`=1 that cycle.
  - Required next cycle: `out_valid`=1, `out_id`=0, `out_tag`=3, `out_n` equals the reference model for that (RB,I,S).
- **Mode sweep:** same RB/I, S=0..7 on consecutive cycles with `out_ready`=1.
  - Required: 8 results, one per cycle, in order, each matching the model.
- **Contention:** both ports valid for 4 cycles after reset, `out_ready`=1.
  - Required grants: 0, 1, 0, 1. `prio` ends at 0.
- **Backpressure:** `out_ready`=0 for 3 cycles with port 1 valid.
  - Required: `req1_ready`=0 and `out_*` held. When `out_ready` rises, the result transfers and port 1 is accepted in the same cycle.
- **Flush and reset:**
  - `flush` with FULL and `out_ready`=1: `out_valid`=0 next, no accept.
  - `rst_n` dropped mid-burst: `out_valid` goes to 0 immediately and `prio` returns to 0.
- **Stats (`SOH_ARB_STATS_EN`):** 70000 port 0 accepts.
  - Required: `grant0_cnt` saturates at 16'hFFFF and `grant1_cnt`=0.
